// File: rtl/bist_signature_checker.sv
// BIST response compactor: folds the CUT scan-out stream into a serial-input signature register,
// counts the shifts of each run, and grades signature and count against golden values at bist_end.
module bist_signature_checker #(
  parameter int          W          = 16,
  parameter logic [W-1:0] POLY      = 16'h1021,
  parameter logic [W-1:0] SEED      = 16'hFFFF,
  parameter logic [W-1:0] GOLDEN    = 16'h0000,
  parameter int          CW         = 16,
  parameter int unsigned EXP_SHIFTS = 13026
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          shift_en,
  input  logic          bist_running,
  input  logic          bist_end,
  input  logic          scan_bit,
  output logic [W-1:0]  signature,
  output logic [CW-1:0] shift_count,
  output logic          done,
  output logic          pass,
  output logic          fail
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPACT,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] EXP_CNT = CW'(EXP_SHIFTS);

  state_t        state, state_next;
  logic [W-1:0]  sig_next;
  logic [CW-1:0] cnt_next;
  logic [CW-1:0] cnt_sat_inc;
  logic          done_next, pass_next, fail_next;
  logic          verdict_ok;

  // One SISR step: shift left, and when the outgoing MSB disagrees with the
  // incoming bit, fold the polynomial back in.
  function automatic logic [W-1:0] sisr_step(input logic [W-1:0] s, input logic b);
    logic fb;
    fb = s[W-1] ^ b;
    return {s[W-2:0], 1'b0} ^ ({W{fb}} & POLY);
  endfunction

  // A saturated counter must never wrap back into a value that could match EXP_CNT.
  assign cnt_sat_inc = (shift_count == CNT_MAX) ? shift_count : shift_count + CW'(1);
  assign verdict_ok  = (signature == GOLDEN) && (shift_count == EXP_CNT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      signature   <= SEED;
      shift_count <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_next;
      signature   <= sig_next;
      shift_count <= cnt_next;
      done        <= done_next;
      pass        <= pass_next;
      fail        <= fail_next;
    end
  end

  // NOTE: every output of this block is given a hold value before the case,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    sig_next   = signature;
    cnt_next   = shift_count;
    done_next  = done;
    pass_next  = pass;
    fail_next  = fail;

    unique case (state)
      // A new run starts on the very cycle bist_running is seen, so a shift
      // arriving alongside it is compacted rather than dropped.
      S_IDLE, S_DONE: begin
        if (bist_running) begin
          state_next = S_COMPACT;
          done_next  = 1'b0;
          pass_next  = 1'b0;
          fail_next  = 1'b0;
          sig_next   = shift_en ? sisr_step(SEED, scan_bit) : SEED;
          cnt_next   = shift_en ? CW'(1) : '0;
        end
      end

      S_COMPACT: begin
        if (bist_end) begin
          state_next = S_CHECK;
        end else if (!bist_running) begin
          state_next = S_IDLE;
          sig_next   = SEED;
          cnt_next   = '0;
        end else if (shift_en) begin
          sig_next = sisr_step(signature, scan_bit);
          cnt_next = cnt_sat_inc;
        end
      end

      S_CHECK: begin
        state_next = S_DONE;
        done_next  = 1'b1;
        pass_next  = verdict_ok;
        fail_next  = !verdict_ok;
      end

      default: state_next = S_IDLE;
    endcase
  end

  a_pass_fail_exclusive: assert property (@(posedge clock) disable iff (!reset)
    !(pass && fail));

  a_flags_need_done: assert property (@(posedge clock) disable iff (!reset)
    !done |-> (!pass && !fail));

endmodule
